// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared CPU definitions used by the writeback path: register-file geometry,
// processor mode encodings and the queued-write entry layout.
package reg_writeback_ctrl_pkg;

  localparam int PC_IDX   = 15;
  localparam int NUM_REGS = 16;
  localparam int MODE_W   = 5;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_USR = 5'h10,
    MODE_FIQ = 5'h11,
    MODE_IRQ = 5'h12,
    MODE_SVC = 5'h13,
    MODE_ABT = 5'h17,
    MODE_UND = 5'h1B,
    MODE_SYS = 5'h1F
  } cpu_mode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MODE_W-1:0] mode;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] regOneHot(input logic [ADDR_W-1:0] regIdx);
    return NUM_REGS'(1) << regIdx;
  endfunction

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Writeback request/issue bundle: the pipeline drives requests in, the
// controller drives register-file and PC write strobes out.
interface reg_writeback_ctrl_if;
  import reg_writeback_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              wb0_en;
  logic [ADDR_W-1:0] wb0_addr;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_en;
  logic [ADDR_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;
  logic [MODE_W-1:0] in_mode;
  logic              flush;

  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                write_reg;
  logic                write_pc;
  logic [DATA_W-1:0]   pc_data;
  logic [MODE_W-1:0]   w_mode;
  logic [NUM_REGS-1:0] pend_mask;

  modport master (
    output in_valid, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
           in_mode, flush,
    input  in_ready, w_addr, w_data, write_reg, write_pc, pc_data, w_mode,
           pend_mask
  );

  modport slave (
    input  in_valid, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
           in_mode, flush,
    output in_ready, w_addr, w_data, write_reg, write_pc, pc_data, w_mode,
           pend_mask
  );

endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Circular write queue: pushes up to two entries and pops at most one per
// cycle, and reports which registers have a queued write outstanding.
module wb_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [1:0]               pushCnt_i,
  input  wb_entry_t                pushA_i,
  input  wb_entry_t                pushB_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     headValid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [NUM_REGS-1:0]      pendMask_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            popEn;

  assign popEn       = pop_i && (count_q != '0);
  assign head_o      = mem_q[rdPtr_q];
  assign headValid_o = (count_q != '0);
  assign count_o     = count_q;

  // Flush drops everything still queued; the head shown this cycle has
  // already been presented to the register file, so it counts as issued.
  always_comb begin
    rdPtr_d = rdPtr_q + PW'(popEn);
    wrPtr_d = wrPtr_q + PW'(pushCnt_i);
    count_d = count_q - CW'(popEn) + CW'(pushCnt_i);
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushCnt_i != 2'd0) begin
      mem_q[wrPtr_q] <= pushA_i;
    end
    if (pushCnt_i == 2'd2) begin
      mem_q[wrPtr_q + PW'(1)] <= pushB_i;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] slotOff;
    slotOff    = '0;
    pendMask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slotOff = PW'(i) - rdPtr_q;
      if ({1'b0, slotOff} < count_q) begin
        pendMask_o = pendMask_o | regOneHot(mem_q[i].addr);
      end
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback controller: queues up to two register writes per request and
// issues them one per cycle to the register file or the PC.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  reg_writeback_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t       wb0Entry, wb1Entry;
  wb_entry_t       pushA, pushB, head;
  logic [1:0]      pushCnt;
  logic            headValid;
  logic            accept;
  logic [CW-1:0]   count;
  logic [CW-1:0]   freeSlots;

  assign wb0Entry = '{addr: bus.wb0_addr, data: bus.wb0_data, mode: bus.in_mode};
  assign wb1Entry = '{addr: bus.wb1_addr, data: bus.wb1_data, mode: bus.in_mode};

  // Room for a worst-case two-write request is required before accepting.
  assign freeSlots    = CW'(DEPTH) - count;
  assign bus.in_ready = (freeSlots >= CW'(2)) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Enabled writes are packed so that disabled slots take no queue entry.
  always_comb begin
    pushCnt = 2'd0;
    pushA   = '0;
    pushB   = '0;
    if (accept) begin
      unique case ({bus.wb0_en, bus.wb1_en})
        2'b11: begin
          pushCnt = 2'd2;
          pushA   = wb0Entry;
          pushB   = wb1Entry;
        end
        2'b10: begin
          pushCnt = 2'd1;
          pushA   = wb0Entry;
        end
        2'b01: begin
          pushCnt = 2'd1;
          pushA   = wb1Entry;
        end
        default: pushCnt = 2'd0;
      endcase
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.flush),
    .pushCnt_i  (pushCnt),
    .pushA_i    (pushA),
    .pushB_i    (pushB),
    .pop_i      (headValid),
    .head_o     (head),
    .headValid_o(headValid),
    .count_o    (count),
    .pendMask_o (bus.pend_mask)
  );

  always_comb begin
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.w_mode    = '0;
    bus.pc_data   = '0;
    bus.write_reg = 1'b0;
    bus.write_pc  = 1'b0;
    if (headValid) begin
      bus.w_addr = head.addr;
      bus.w_data = head.data;
      bus.w_mode = head.mode;
      if (head.addr == ADDR_W'(PC_IDX)) begin
        bus.write_pc = 1'b1;
        bus.pc_data  = head.data;
      end else begin
        bus.write_reg = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_writeback_ctrl_if bus();

  reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wb_entry_t modelQ[$];
  int        nChecks = 0;
  int        nPassed = 0;
  bit        lastAccepted = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [15:0] modelPend();
    logic [15:0] m = '0;
    foreach (modelQ[i]) m[modelQ[i].addr] = 1'b1;
    return m;
  endfunction

  // One cycle: drive inputs after the falling edge, check outputs, then
  // advance the model to what the next rising edge should produce.
  task automatic applyStimulus(input bit rstV, input bit validV,
                               input bit en0, input logic [3:0] a0, input logic [31:0] d0,
                               input bit en1, input logic [3:0] a1, input logic [31:0] d1,
                               input logic [4:0] mode, input bit flushV);
    wb_entry_t head;
    bit        expReady;
    @(negedge clk);
    rst          = rstV;
    bus.in_valid = validV;
    bus.wb0_en   = en0;
    bus.wb0_addr = a0;
    bus.wb0_data = d0;
    bus.wb1_en   = en1;
    bus.wb1_addr = a1;
    bus.wb1_data = d1;
    bus.in_mode  = mode;
    bus.flush    = flushV;
    #1;
    expReady = ((DEPTH - modelQ.size()) >= 2) && !flushV;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
    if (modelQ.size() > 0) begin
      head = modelQ[0];
      checkOutput("write_reg", 32'(bus.write_reg), 32'(head.addr != 4'd15));
      checkOutput("write_pc", 32'(bus.write_pc), 32'(head.addr == 4'd15));
      checkOutput("w_addr", 32'(bus.w_addr), 32'(head.addr));
      checkOutput("w_mode", 32'(bus.w_mode), 32'(head.mode));
      if (head.addr == 4'd15) checkOutput("pc_data", bus.pc_data, head.data);
      else checkOutput("w_data", bus.w_data, head.data);
    end else begin
      checkOutput("idle_write_reg", 32'(bus.write_reg), 32'd0);
      checkOutput("idle_write_pc", 32'(bus.write_pc), 32'd0);
      checkOutput("idle_w_addr", 32'(bus.w_addr), 32'd0);
      checkOutput("idle_w_data", bus.w_data, 32'd0);
      checkOutput("idle_pc_data", bus.pc_data, 32'd0);
      checkOutput("idle_w_mode", 32'(bus.w_mode), 32'd0);
    end
    checkOutput("pend_mask", 32'(bus.pend_mask), 32'(modelPend()));
    lastAccepted = validV && expReady && !rstV;
    if (rstV) begin
      modelQ.delete();
    end else begin
      if (modelQ.size() > 0) void'(modelQ.pop_front());
      if (flushV) modelQ.delete();
      else if (lastAccepted) begin
        if (en0) modelQ.push_back('{addr: a0, data: d0, mode: mode});
        if (en1) modelQ.push_back('{addr: a1, data: d1, mode: mode});
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, MODE_USR, 0);
  endtask

  task automatic pairRequest(input logic [3:0] a0, input logic [31:0] d0,
                             input logic [3:0] a1, input logic [31:0] d1);
    applyStimulus(0, 1, 1, a0, d0, 1, a1, d1, MODE_SVC, 0);
  endtask

  logic [4:0] modeTable [7] = '{MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
                                MODE_ABT, MODE_UND, MODE_SYS};

  initial begin
    bus.in_valid = 0; bus.wb0_en = 0; bus.wb0_addr = 0; bus.wb0_data = 0;
    bus.wb1_en = 0; bus.wb1_addr = 0; bus.wb1_data = 0;
    bus.in_mode = 0; bus.flush = 0;
    repeat (2) @(posedge clk);

    // Reset state, then a single write to r3 in user mode.
    applyStimulus(0, 1, 1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'd0, 5'h10, 0);
    idleCycle();
    checkOutput("single_w_data", bus.w_data, 32'hDEADBEEF);
    checkOutput("single_pend", 32'(bus.pend_mask), 32'h0008);
    checkOutput("single_w_mode", 32'(bus.w_mode), 32'h10);

    // Register write followed by a PC write from the same request.
    applyStimulus(0, 1, 1, 4'd1, 32'h11, 1, 4'd15, 32'h8000, MODE_IRQ, 0);
    idleCycle();
    checkOutput("pair_r1_strobe", 32'(bus.write_reg), 32'd1);
    checkOutput("pair_r1_addr", 32'(bus.w_addr), 32'd1);
    idleCycle();
    checkOutput("pair_pc_strobe", 32'(bus.write_pc), 32'd1);
    checkOutput("pair_pc_data", bus.pc_data, 32'h8000);
    checkOutput("pair_pc_noreg", 32'(bus.write_reg), 32'd0);
    idleCycle();

    // Three back-to-back pairs: the third must wait for queue space.
    pairRequest(4'd2, 32'hA0, 4'd4, 32'hA1);
    pairRequest(4'd5, 32'hA2, 4'd6, 32'hA3);
    pairRequest(4'd7, 32'hA4, 4'd7, 32'hA5);
    checkOutput("full_ready_drop", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 8 && !lastAccepted; k++) pairRequest(4'd7, 32'hA4, 4'd7, 32'hA5);
    checkOutput("full_third_accepted", 32'(lastAccepted), 32'd1);
    for (int k = 0; k < 8; k++) idleCycle();

    // Flush with three entries queued: head still issued, then silence.
    pairRequest(4'd4, 32'hB0, 4'd5, 32'hB1);
    pairRequest(4'd6, 32'hB2, 4'd7, 32'hB3);
    applyStimulus(0, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, MODE_USR, 1);
    checkOutput("flush_head_issued", 32'(bus.write_reg), 32'd1);
    idleCycle();
    checkOutput("flush_after_strobe", 32'(bus.write_reg | bus.write_pc), 32'd0);
    checkOutput("flush_after_pend", 32'(bus.pend_mask), 32'd0);

    // Reset while draining drops the remaining writes.
    pairRequest(4'd2, 32'hC0, 4'd3, 32'hC1);
    idleCycle();
    applyStimulus(1, 1, 1, 4'd9, 32'hC2, 0, 4'd0, 32'd0, MODE_USR, 1);
    idleCycle();
    checkOutput("rst_after_strobe", 32'(bus.write_reg | bus.write_pc), 32'd0);
    checkOutput("rst_after_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_after_pend", 32'(bus.pend_mask), 32'd0);

    // Random traffic, biased toward PC writes and same-address pairs.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ra0, ra1;
      ra0 = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 4) == 0) ? ra0 : 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 70,
                    1'($urandom), ra0, $urandom,
                    1'($urandom), ra1, $urandom,
                    modeTable[$urandom_range(0, 6)],
                    $urandom_range(0, 99) < 5);
    end
    for (int k = 0; k < 6; k++) idleCycle();

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
